// File: rtl/s526_step_controller_if.sv
// Host/debug command channel for the s526 step controller.
// A command transfers on a rising edge where cmd_valid and cmd_ready are both high.
interface s526_step_controller_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/s526_step_controller.sv
// State-register bank and sequencer for the s526 combinational core:
// free-run, counted step and serial scan load/unload of the state vector.
module s526_step_controller #(
  parameter int                 STATE_W     = 21,
  parameter int                 CNT_W       = 16,
  parameter logic [STATE_W-1:0] RESET_STATE = {STATE_W{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  s526_step_controller_if.slave cmd,
  input  logic [STATE_W-1:0]    next_state,
  output logic [STATE_W-1:0]    state_q,
  input  logic                  scan_in,
  output logic                  scan_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           cycle_cnt
);
  localparam int SH_W = $clog2(STATE_W + 1);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_SCAN = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, SCAN = 2'd3} fsm_t;

  fsm_t             fsm_r, fsm_s;
  logic [CNT_W-1:0] step_cnt_r, step_cnt_s;
  logic [SH_W-1:0]  shift_cnt_r, shift_cnt_s;
  logic [STATE_W-1:0] state_s;
  logic [31:0]      cycle_cnt_s;
  logic             done_s, err_s, accept_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) return v;
    else                    return v + 32'd1;
  endfunction

  // Ready is decoded straight from the FSM so IDLE/RUN accept without delay.
  always_comb begin
    case (fsm_r)
      IDLE:    cmd.cmd_ready = 1'b1;
      RUN:     cmd.cmd_ready = 1'b1;
      default: cmd.cmd_ready = 1'b0;
    endcase
  end

  assign accept_s = cmd.cmd_valid & cmd.cmd_ready;
  assign scan_out = state_q[0];

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    fsm_s       = fsm_r;
    step_cnt_s  = step_cnt_r;
    shift_cnt_s = shift_cnt_r;
    state_s     = state_q;
    cycle_cnt_s = cycle_cnt;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (fsm_r)
      IDLE: begin
        if (accept_s) begin
          case (cmd.cmd_op)
            OP_RUN:  fsm_s = RUN;
            OP_STEP: begin
              if (cmd.cmd_arg != {CNT_W{1'b0}}) begin
                fsm_s      = STEP;
                step_cnt_s = cmd.cmd_arg;
              end else begin
                done_s = 1'b1;
              end
            end
            OP_SCAN: begin
              fsm_s       = SCAN;
              shift_cnt_s = SH_W'(STATE_W);
            end
            default: fsm_s = IDLE;
          endcase
        end else begin
          fsm_s = IDLE;
        end
      end
      RUN: begin
        // The edge that takes HALT must not commit; anything else is discarded with err.
        if (accept_s && (cmd.cmd_op == OP_HALT)) begin
          fsm_s = IDLE;
        end else begin
          state_s     = next_state;
          cycle_cnt_s = sat_inc(cycle_cnt);
          err_s       = accept_s;
        end
      end
      STEP: begin
        state_s     = next_state;
        cycle_cnt_s = sat_inc(cycle_cnt);
        step_cnt_s  = step_cnt_r - CNT_W'(1);
        if (step_cnt_r == CNT_W'(1)) begin
          fsm_s  = IDLE;
          done_s = 1'b1;
        end else begin
          fsm_s = STEP;
        end
      end
      SCAN: begin
        state_s     = {scan_in, state_q[STATE_W-1:1]};
        shift_cnt_s = shift_cnt_r - SH_W'(1);
        if (shift_cnt_r == SH_W'(1)) begin
          fsm_s  = IDLE;
          done_s = 1'b1;
        end else begin
          fsm_s = SCAN;
        end
      end
      default: fsm_s = IDLE;
    endcase
  end

  // Register bank; reset abandons any in-flight operation without a done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r       <= IDLE;
      state_q     <= RESET_STATE;
      step_cnt_r  <= {CNT_W{1'b0}};
      shift_cnt_r <= {SH_W{1'b0}};
      cycle_cnt   <= 32'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      fsm_r       <= fsm_s;
      state_q     <= state_s;
      step_cnt_r  <= step_cnt_s;
      shift_cnt_r <= shift_cnt_s;
      cycle_cnt   <= cycle_cnt_s;
      done        <= done_s;
      err         <= err_s;
      busy        <= (fsm_s != IDLE);
    end
  end
endmodule

// File: tb/tb_s526_step_controller.sv
// Self-checking bench for s526_step_controller; next_state is modelled as state_q + 1.
module tb_s526_step_controller;
  localparam int STATE_W = 21;
  localparam int CNT_W   = 16;
  localparam logic [1:0] OP_RUN = 2'b00, OP_STEP = 2'b01, OP_SCAN = 2'b10, OP_HALT = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [STATE_W-1:0] next_state, state_q;
  logic scan_in, scan_out, busy, done, err;
  logic [31:0] cycle_cnt;

  int errors = 0;
  int checks = 0;
  logic [STATE_W-1:0] exp_q[$];
  logic [STATE_W-1:0] model_state;
  logic [31:0]        model_cnt;

  always #5 clk = ~clk;

  s526_step_controller_if #(.CNT_W(CNT_W)) cmd_bus ();

  assign next_state = state_q + 21'd1;

  s526_step_controller #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_bus.slave),
    .next_state(next_state), .state_q(state_q), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_arg   = arg;
    tick();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (state_q !== 21'd0) begin errors++; $display("FAIL reset_state got %h exp %h", state_q, 21'd0); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, err}); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", cycle_cnt); end
    checks++; if (cmd_bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_bus.cmd_ready); end
    rst_n = 1'b1;
    tick();
    model_state = 21'd0;
    model_cnt   = 32'd0;
  endtask

  task automatic test_step3();
    int dones = 0;
    for (int i = 1; i <= 3; i++) exp_q.push_back(model_state + STATE_W'(i));
    issue(OP_STEP, 16'd3);
    checks++; if ({busy, cmd_bus.cmd_ready} !== 2'b10) begin errors++; $display("FAIL step3_busy got %b exp 10", {busy, cmd_bus.cmd_ready}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dones++;
      checks++;
      if (state_q !== exp_q[0]) begin errors++; $display("FAIL step3_state got %h exp %h", state_q, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL step3_done got %b exp 1", done); end
    checks++; if ({busy, cmd_bus.cmd_ready} !== 2'b01) begin errors++; $display("FAIL step3_idle got %b exp 01", {busy, cmd_bus.cmd_ready}); end
    model_state = model_state + 21'd3;
    model_cnt   = model_cnt + 32'd3;
    checks++; if (cycle_cnt !== model_cnt) begin errors++; $display("FAIL step3_cnt got %0d exp %0d", cycle_cnt, model_cnt); end
    tick();
    if (done === 1'b1) dones++;
    checks++; if (dones != 1) begin errors++; $display("FAIL step3_pulses got %0d exp 1", dones); end
    checks++; if (state_q !== model_state) begin errors++; $display("FAIL step3_hold got %h exp %h", state_q, model_state); end
  endtask

  task automatic do_scan(input logic [STATE_W-1:0] din);
    for (int k = 0; k < STATE_W; k++) exp_q.push_back({{(STATE_W-1){1'b0}}, model_state[k]});
    issue(OP_SCAN, 16'd0);
    for (int k = 0; k < STATE_W; k++) begin
      checks++;
      if ({{(STATE_W-1){1'b0}}, scan_out} !== exp_q[0]) begin errors++; $display("FAIL scan_out bit %0d got %b exp %b", k, scan_out, exp_q[0][0]); end
      void'(exp_q.pop_front());
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL scan_early_done bit %0d got %b exp 0", k, done); end
      scan_in = din[k];
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL scan_done got %b exp 1", done); end
    checks++; if (state_q !== din) begin errors++; $display("FAIL scan_state got %h exp %h", state_q, din); end
    checks++; if (cycle_cnt !== model_cnt) begin errors++; $display("FAIL scan_cnt got %0d exp %0d", cycle_cnt, model_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy got %b exp 0", busy); end
    model_state = din;
  endtask

  task automatic test_scan();
    do_scan(21'h1ABCDE);
    do_scan(21'h155555);
  endtask

  task automatic test_run_err();
    issue(OP_RUN, 16'd0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (state_q !== model_state + 21'd10) begin errors++; $display("FAIL run_state got %h exp %h", state_q, model_state + 21'd10); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL run_err_idle got %b exp 0", err); end
    issue(OP_STEP, 16'd5);
    checks++; if ({err, busy} !== 2'b11) begin errors++; $display("FAIL run_err_pulse got %b exp 11", {err, busy}); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL run_err_once got %b exp 0", err); end
    issue(OP_HALT, 16'd0);
    model_state = model_state + 21'd12;
    model_cnt   = model_cnt + 32'd12;
    checks++; if (state_q !== model_state) begin errors++; $display("FAIL halt_state got %h exp %h", state_q, model_state); end
    checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL halt_flags got %b exp 00", {busy, err}); end
    tick();
    tick();
    checks++; if (state_q !== model_state) begin errors++; $display("FAIL halt_hold got %h exp %h", state_q, model_state); end
    checks++; if (cycle_cnt !== model_cnt) begin errors++; $display("FAIL halt_cnt got %0d exp %0d", cycle_cnt, model_cnt); end
  endtask

  task automatic test_step0();
    issue(OP_STEP, 16'd0);
    checks++; if ({done, cmd_bus.cmd_ready, busy} !== 3'b110) begin errors++; $display("FAIL step0_flags got %b exp 110", {done, cmd_bus.cmd_ready, busy}); end
    checks++; if (state_q !== model_state) begin errors++; $display("FAIL step0_state got %h exp %h", state_q, model_state); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL step0_pulse got %b exp 0", done); end
    checks++; if (cycle_cnt !== model_cnt) begin errors++; $display("FAIL step0_cnt got %0d exp %0d", cycle_cnt, model_cnt); end
  endtask

  task automatic test_reset_mid_step();
    int dones = 0;
    issue(OP_STEP, 16'd100);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (state_q !== 21'd0) begin errors++; $display("FAIL midrst_state got %h exp 0", state_q); end
    checks++; if ({busy, done, cycle_cnt} !== 34'd0) begin errors++; $display("FAIL midrst_flags got %b %b %h exp 0", busy, done, cycle_cnt); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_done got %0d exp 0", dones); end
    model_state = 21'd0;
    model_cnt   = 32'd0;
    issue(OP_STEP, 16'd2);
    tick();
    tick();
    checks++; if ({state_q, done} !== {21'd2, 1'b1}) begin errors++; $display("FAIL midrst_step2 got %h/%b exp 2/1", state_q, done); end
    tick();
    checks++; if ({state_q, cycle_cnt} !== {21'd2, 32'd2}) begin errors++; $display("FAIL midrst_hold got %h/%0d exp 2/2", state_q, cycle_cnt); end
    model_state = 21'd2;
    model_cnt   = 32'd2;
  endtask

  task automatic test_saturate();
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.cycle_cnt;
    tick();
    checks++; if (cycle_cnt !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got %h exp FFFFFFFE", cycle_cnt); end
    issue(OP_STEP, 16'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cycle_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_cnt got %h exp FFFFFFFF", cycle_cnt); end
    end
    checks++; if ({state_q, done} !== {model_state + 21'd3, 1'b1}) begin errors++; $display("FAIL sat_state got %h/%b exp %h/1", state_q, done, model_state + 21'd3); end
  endtask

  initial begin
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = OP_RUN;
    cmd_bus.cmd_arg   = 16'd0;
    scan_in           = 1'b0;
    model_state       = 21'd0;
    model_cnt         = 32'd0;
    test_reset();
    test_step3();
    test_scan();
    test_run_err();
    test_step0();
    test_reset_mid_step();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/s526_step_controller.md
# s526_step_controller

Sequencing controller that owns the state-register bank of the s526 combinational core and decides when that core's next-state vector is committed. It sits between a host/debug command port and the core, supporting:
- free-running execution;
- counted single/multi-step execution;
- full serial scan of the state vector for load/unload.

The core stays purely combinational. This block is the only place state is stored.

## Interface
Parameters:
- STATE_W, 21, width of the core state vector (bit mapping fixed by the core wrapper).
- CNT_W, 16, width of step-count argument and step counter.
- RESET_STATE, 0, value loaded into state_q on reset.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  reset; synchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 RUN, 01 STEP, 10 SCAN, 11 HALT.
- cmd_arg  input  CNT_W  step count for STEP; ignored otherwise.
- next_state  input  STATE_W  next-state vector from the core.
- state_q  output  STATE_W  registered state driven to the core inputs.
- scan_in  input  1  serial scan data in.
- scan_out  output  1  equals state_q[0].
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at STEP or SCAN completion.
- err  output  1  one-cycle pulse on an illegal command.
- cycle_cnt  output  32  count of functional state commits, saturating at 0xFFFF_FFFF.

## Operation
- FSM states: IDLE, RUN, STEP, SCAN.
- Acceptance: a command is accepted on a rising edge where cmd_valid and cmd_ready are both high.
- cmd_ready: 1 in IDLE and RUN, 0 in STEP and SCAN.
- IDLE:
  - state_q holds.
  - RUN goes to RUN.
  - STEP with arg>0 goes to STEP with step_cnt=arg.
  - STEP with arg=0 stays in IDLE and pulses done next cycle.
  - SCAN goes to SCAN with shift_cnt=STATE_W.
  - HALT is a no-op with no err.
- RUN:
  - Every cycle, state_q<=next_state and cycle_cnt increments.
  - HALT goes to IDLE. The edge that accepts HALT does not commit.
  - Any other op is accepted and discarded, pulses err, and RUN continues.
- STEP:
  - Every cycle, state_q<=next_state, cycle_cnt increments and step_cnt decrements.
  - When step_cnt reaches 0, go to IDLE and pulse done that same edge.
- SCAN:
  - Every cycle, state_q<={scan_in, state_q[STATE_W-1:1]} and shift_cnt decrements.
  - When shift_cnt reaches 0, go to IDLE and pulse done.
  - cycle_cnt is unchanged.
- Unloading: the old contents appear on scan_out LSB-first, one bit per cycle, starting the cycle after acceptance.
- Reset (any state, mid-operation included): go to IDLE; state_q=RESET_STATE; step_cnt=0, shift_cnt=0, cycle_cnt=0; done=0, err=0. In-flight STEP/SCAN is abandoned and no done is issued.

## Timing
- First commit or shift occurs on the edge after the accepting edge.
- STEP latency: STEP n commits exactly n times. done is registered and high in the cycle after the n-th commit edge. cmd_ready returns high in that same cycle.
- SCAN latency: exactly STATE_W shifts. done is high in the cycle after the last shift.
- A new command may be accepted in the same cycle done is high.
- cycle_cnt saturation: stays at 0xFFFF_FFFF and never wraps.
- step_cnt width: CNT_W. The maximum step is 2^CNT_W-1.
- Outputs are registered except cmd_ready (decoded from the FSM state) and scan_out (wire from state_q[0]).

## Test plan
- Reset then STEP arg=3, next_state tied to state_q+1 -> state_q 0→1→2→3 on 3 consecutive edges; done pulses once; cycle_cnt=3; busy low afterwards.
- SCAN with scan_in sequence 1,0,1,... (21 bits) from state_q=0x1ABCDE -> scan_out emits 0x1ABCDE LSB-first; final state_q equals shifted-in pattern; cycle_cnt unchanged.
- RUN for 10 cycles, then STEP offered mid-RUN, then HALT -> err pulses once; RUN continues; exactly 10 commits before HALT (plus those during the STEP offer cycle); state holds after HALT.
- STEP arg=0 -> no commit; done pulses next cycle; cmd_ready stays 1.
- rst_n low for one cycle at STEP count 5 of 100 -> state_q=RESET_STATE, IDLE, no done; a following STEP 2 commits exactly 2 times.
- Force cycle_cnt near max (RUN 2^32 or a backdoor preload to 0xFFFF_FFFE) then 3 commits -> cycle_cnt stays 0xFFFF_FFFF.
